// File: rtl/data_memory_stage.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_stage
// Description : MEM stage of the 8-bit five-stage pipeline. Performs loads,
//               stores or ALU pass-through against a flop-based data memory,
//               registers the result for write-back, and flags out-of-range
//               accesses (pulse) and illegal rd+wr decodes (sticky).
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory_stage #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] ans_ex,
    input  logic [DATA_W-1:0] st_data,
    input  logic              mem_rd,
    input  logic              mem_wr,
    output logic [DATA_W-1:0] ans_dm,
    output logic              dm_valid,
    output logic              addr_err,
    output logic              op_err
);

    localparam int C_DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [C_DEPTH];
    logic [DATA_W-1:0] r_ans_dm;
    logic              r_dm_valid;
    logic              r_addr_err;
    logic              r_op_err;

    logic              w_in_range;
    logic [ADDR_W-1:0] w_addr;
    logic              w_is_load;
    logic              w_is_store;
    logic              w_is_illegal;
    logic              w_is_access;
    logic              w_wr_en;
    logic [DATA_W-1:0] w_rd_data;

    // Any set bit above the address field means the access is out of range;
    // such addresses are rejected rather than wrapped onto the array.
    assign w_in_range   = (ans_ex[DATA_W-1:ADDR_W] == '0);
    assign w_addr       = ans_ex[ADDR_W-1:0];
    assign w_is_load    = in_valid &  mem_rd & ~mem_wr;
    assign w_is_store   = in_valid & ~mem_rd &  mem_wr;
    assign w_is_illegal = in_valid &  mem_rd &  mem_wr;
    assign w_is_access  = in_valid & (mem_rd | mem_wr);
    assign w_wr_en      = w_is_store & w_in_range;

    // Asynchronous read: a load observes every store committed at earlier
    // edges, so a store followed directly by a load needs no bypass path.
    assign w_rd_data    = r_mem[w_addr];

    // Data memory: cleared on reset (which also drops any concurrent store),
    // otherwise written by in-range stores only.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < C_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[w_addr] <= st_data;
        end
    end

    // Stage output register: load data or pass-through result; held on bubbles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ans_dm   <= '0;
            r_dm_valid <= 1'b0;
        end else begin
            r_dm_valid <= in_valid;
            if (w_is_load) begin
                r_ans_dm <= w_in_range ? w_rd_data : '0;
            end else if (in_valid) begin
                r_ans_dm <= ans_ex;
            end
        end
    end

    // Error flags: addr_err re-evaluated every cycle, op_err held until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr_err <= 1'b0;
            r_op_err   <= 1'b0;
        end else begin
            r_addr_err <= w_is_access & ~w_in_range;
            if (w_is_illegal) begin
                r_op_err <= 1'b1;
            end
        end
    end

    assign ans_dm   = r_ans_dm;
    assign dm_valid = r_dm_valid;
    assign addr_err = r_addr_err;
    assign op_err   = r_op_err;

endmodule
`default_nettype wire
